// File: rtl/readout_stream_multi.sv
// Streams the enabled cells' readout entries from the cell-comm DPRAM as an indexed beat stream
// after each readout cycle, zero-filling the frame when readoutValid never arrives.
module readout_stream_multi #(
    parameter int ADDR_WIDTH       = 9,
    parameter int DATA_WIDTH       = 32,
    parameter int CELL_COUNT       = 2,
    parameter int ENTRIES_PER_CELL = 32,
    parameter int FIRST_ADDRESS    = 32,
    parameter int TIMEOUT_CYCLES   = 1000
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  readoutActive,
    input  logic                  readoutValid,
    input  logic [CELL_COUNT-1:0] cellEnable,
    output logic [ADDR_WIDTH-1:0] readoutAddress,
    input  logic [DATA_WIDTH-1:0] readoutData,
    input  logic                  readoutPresent,
    output logic [ADDR_WIDTH-1:0] packetIndex,
    output logic [DATA_WIDTH-1:0] packetData,
    output logic                  packetValid,
    input  logic                  packetReady,
    output logic                  packetLast,
    output logic                  frameDone,
    output logic                  timedOut,
    output logic [15:0]           timeoutCount
);
    localparam int CW = (CELL_COUNT > 1) ? $clog2(CELL_COUNT) : 1;
    localparam int EW = (ENTRIES_PER_CELL > 1) ? $clog2(ENTRIES_PER_CELL) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, ACTIVE, WAIT, STREAM, DRAIN} state_t;
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] idx;
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } beat_t;

    // Lowest enabled cell at or above 'from'; CELL_COUNT when there is none.
    function automatic int unsigned next_cell(input logic [CELL_COUNT-1:0] mask, input int unsigned from);
        logic [CELL_COUNT-1:0] sh;
        int unsigned r;
        r = CELL_COUNT;
        for (int unsigned i = 0; i < CELL_COUNT; i++) begin
            sh = mask >> i;
            if (i >= from && sh[0] && r == CELL_COUNT) r = i;
        end
        return r;
    endfunction

    state_t                state_q, state_d;
    logic                  act_prev_q, act_prev_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [15:0]           tmo_cnt_q, tmo_cnt_d;
    logic                  timed_out_q, timed_out_d;
    logic [CELL_COUNT-1:0] enable_q, enable_d;
    logic [CW-1:0]         cell_q, cell_d;
    logic [EW-1:0]         entry_q, entry_d;
    logic                  more_q, more_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rd1_q, rd1_d, last1_q, last1_d;
    logic                  rd2_q, rd2_d, last2_q, last2_d;
    logic [ADDR_WIDTH-1:0] idx2_q, idx2_d;
    beat_t                 out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    beat_t                 fifo_q [2];
    beat_t                 fifo_d [2];
    logic [1:0]            count_q, count_d;
    logic                  frame_done_q, frame_done_d;

    logic        depart, issue_ok, start, start_zero, push;
    int unsigned held, first, nxt;
    beat_t       in_beat;

    always_comb begin
        state_d      = state_q;
        act_prev_d   = readoutActive;
        timer_d      = timer_q;
        tmo_cnt_d    = tmo_cnt_q;
        timed_out_d  = timed_out_q;
        enable_d     = enable_q;
        cell_d       = cell_q;
        entry_d      = entry_q;
        more_d       = more_q;
        addr_d       = addr_q;
        rd1_d        = 1'b0;
        last1_d      = last1_q;
        rd2_d        = rd1_q;
        last2_d      = last1_q;
        idx2_d       = addr_q;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        fifo_d       = fifo_q;
        count_d      = count_q;
        frame_done_d = 1'b0;
        start        = 1'b0;
        start_zero   = 1'b0;
        push         = rd2_q;

        depart = out_valid_q && packetReady;
        // Output register, two buffer slots and two pipeline stages: the three storage slots
        // can never be oversubscribed, yet a steady ready stream still gets one beat per cycle.
        held     = 32'(out_valid_q) + 32'(count_q) + 32'(rd1_q) + 32'(rd2_q) - 32'(depart);
        issue_ok = held < 3;
        first    = next_cell(cellEnable, 0);
        nxt      = next_cell(enable_q, 32'(cell_q) + 32'd1);

        case (state_q)
            IDLE:   if (readoutActive && !act_prev_q) state_d = ACTIVE;
            ACTIVE: if (!readoutActive) begin
                        state_d = WAIT;
                        timer_d = '0;
                    end
            WAIT: begin
                if (readoutValid) begin
                    start = 1'b1;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    start      = 1'b1;
                    start_zero = 1'b1;
                    if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + 16'd1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STREAM: begin
                if (!more_q) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end else if (issue_ok) begin
                    addr_d = ADDR_WIDTH'(FIRST_ADDRESS) + ADDR_WIDTH'(cell_q) * ADDR_WIDTH'(ENTRIES_PER_CELL)
                           + ADDR_WIDTH'(entry_q);
                    rd1_d  = 1'b1;
                    if (entry_q == EW'(ENTRIES_PER_CELL - 1)) begin
                        entry_d = '0;
                        last1_d = (nxt == CELL_COUNT);
                        if (nxt == CELL_COUNT) begin
                            more_d  = 1'b0;
                            state_d = DRAIN;
                        end else begin
                            cell_d = CW'(nxt);
                        end
                    end else begin
                        entry_d = entry_q + 1'b1;
                        last1_d = 1'b0;
                    end
                end
            end
            DRAIN: if (depart && out_q.last) begin
                       state_d      = IDLE;
                       frame_done_d = 1'b1;
                   end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d     = STREAM;
            timed_out_d = start_zero;
            enable_d    = cellEnable;
            more_d      = (first != CELL_COUNT);
            cell_d      = (first != CELL_COUNT) ? CW'(first) : '0;
            entry_d     = '0;
        end

        in_beat.idx  = idx2_q;
        in_beat.data = (timed_out_q || !readoutPresent) ? '0 : readoutData;
        in_beat.last = last2_q;

        if (!out_valid_q || depart) begin
            if (count_q != 2'd0) begin
                out_d       = fifo_q[0];
                out_valid_d = 1'b1;
                fifo_d[0]   = fifo_q[1];
                count_d     = count_q - 2'd1;
            end else if (rd2_q) begin
                out_d       = in_beat;
                out_valid_d = 1'b1;
                push        = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end
        if (push) begin
            fifo_d[count_d[0]] = in_beat;
            count_d            = count_d + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            act_prev_q   <= 1'b0;
            timer_q      <= '0;
            tmo_cnt_q    <= '0;
            timed_out_q  <= 1'b0;
            enable_q     <= '0;
            cell_q       <= '0;
            entry_q      <= '0;
            more_q       <= 1'b0;
            addr_q       <= '0;
            rd1_q        <= 1'b0;
            last1_q      <= 1'b0;
            rd2_q        <= 1'b0;
            last2_q      <= 1'b0;
            idx2_q       <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            fifo_q       <= '{default: '0};
            count_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            act_prev_q   <= act_prev_d;
            timer_q      <= timer_d;
            tmo_cnt_q    <= tmo_cnt_d;
            timed_out_q  <= timed_out_d;
            enable_q     <= enable_d;
            cell_q       <= cell_d;
            entry_q      <= entry_d;
            more_q       <= more_d;
            addr_q       <= addr_d;
            rd1_q        <= rd1_d;
            last1_q      <= last1_d;
            rd2_q        <= rd2_d;
            last2_q      <= last2_d;
            idx2_q       <= idx2_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            fifo_q       <= fifo_d;
            count_q      <= count_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign readoutAddress = addr_q;
    assign packetIndex    = out_q.idx;
    assign packetData     = out_q.data;
    assign packetLast     = out_q.last;
    assign packetValid    = out_valid_q;
    assign frameDone      = frame_done_q;
    assign timedOut       = timed_out_q;
    assign timeoutCount   = tmo_cnt_q;
endmodule
